// File: rtl/clk_period_monitor.sv
// ---------------------------------------------------------------------------
// clk_period_monitor
//
// Receive-side checker for the slow divided clock. The slow square wave is
// synchronized into the fast clk domain and every rising-edge-to-rising-edge
// period is measured in clk cycles. Periods outside EXP_PERIOD +/- TOL raise
// sticky error flags, a missing edge raises a sticky timeout, and a run of
// LOCK_CNT consecutive good periods asserts locked.
//
// Parameters:
//   EXP_PERIOD : expected period in clk cycles
//   TOL        : allowed absolute deviation from EXP_PERIOD (inclusive)
//   LOCK_CNT   : consecutive good periods required for locked
//   CW         : counter / period_out width, 2*EXP_PERIOD must fit
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   sig_in       in   monitored slow clock, asynchronous to clk
//   en           in   measurement enable
//   clr_err      in   clears sticky error flags
//   rise_pulse   out  one-cycle strobe per synchronized rising edge
//   fall_pulse   out  one-cycle strobe per synchronized falling edge
//   period_out   out  last measured period (CW bits)
//   period_valid out  one-cycle strobe when period_out updates
//   locked       out  LOCK_CNT consecutive good periods seen
//   err_fast     out  sticky, a period below EXP_PERIOD-TOL was measured
//   err_slow     out  sticky, a period above EXP_PERIOD+TOL was measured
//   err_timeout  out  sticky, no rising edge for 2*EXP_PERIOD cycles
// ---------------------------------------------------------------------------
module clk_period_monitor #(
    parameter int EXP_PERIOD = 2000002,
    parameter int TOL        = 16,
    parameter int LOCK_CNT   = 4,
    parameter int CW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    input  logic          en,
    input  logic          clr_err,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] period_out,
    output logic          period_valid,
    output logic          locked,
    output logic          err_fast,
    output logic          err_slow,
    output logic          err_timeout
);

    localparam int RW = $clog2(LOCK_CNT + 1);

    // Range and timeout constants folded at elaboration.
    localparam logic [CW-1:0] LO_BOUND = CW'(EXP_PERIOD - TOL);
    localparam logic [CW-1:0] HI_BOUND = CW'(EXP_PERIOD + TOL);
    localparam logic [CW-1:0] TIMEOUT  = CW'(2 * EXP_PERIOD);
    localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_run;

    logic            w_take;
    logic            w_timeout;
    logic            w_good;
    logic            w_fast;
    logic            w_slow;
    logic [RW-1:0]   w_run_inc;

    // -----------------------------------------------------------------------
    // Synchronizer and edge detect. r_s1/r_s2 resolve metastability on the
    // asynchronous input; r_s3 is the history bit for edge detection. This
    // path runs regardless of en so the strobes stay observable when idle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // the pre-edge value of the others, matching real hardware.
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise_pulse = r_s2 & ~r_s3;
    assign fall_pulse = ~r_s2 & r_s3;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. Dropping en wins over everything, including an
    // edge arriving in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_ARM;
                ST_ARM:     if (rise_pulse) w_state_next = ST_MEASURE;
                ST_MEASURE: if (w_timeout)  w_state_next = ST_ARM;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output decode. One-cycle measurement events derived from the
    // current state, the edge strobe and the running count.
    // -----------------------------------------------------------------------
    always_comb begin
        w_take    = 1'b0;
        w_timeout = 1'b0;
        if (en && (r_state == ST_MEASURE)) begin
            w_take    = rise_pulse;
            // An edge in the same cycle as the limit is measured, not timed out.
            w_timeout = !rise_pulse && (r_cnt == TIMEOUT);
        end
        w_fast    = w_take && (r_cnt < LO_BOUND);
        w_slow    = w_take && (r_cnt > HI_BOUND);
        w_good    = w_take && !w_fast && !w_slow;
        w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + RW'(1);
    end

    // -----------------------------------------------------------------------
    // Datapath: period counter, lock run, sticky error flags.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_run        <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_fast     <= 1'b0;
            err_slow     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            period_valid <= w_take;
            if (w_take) begin
                period_out <= r_cnt;
            end

            // Count restarts at 1 on the edge so the reported value equals
            // the number of clk cycles between consecutive rise strobes.
            case (w_state_next)
                ST_MEASURE: r_cnt <= rise_pulse ? CW'(1) : r_cnt + CW'(1);
                default:    r_cnt <= '0;
            endcase

            if (!en || w_fast || w_slow || w_timeout) begin
                r_run  <= '0;
                locked <= 1'b0;
            end else if (w_good) begin
                r_run  <= w_run_inc;
                locked <= (w_run_inc == RUN_MAX);
            end

            // A new event sets its flag even when clr_err is asserted.
            err_fast    <= w_fast    | (err_fast    & ~clr_err);
            err_slow    <= w_slow    | (err_slow    & ~clr_err);
            err_timeout <= w_timeout | (err_timeout & ~clr_err);
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_period_monitor
//
// Drives clk-aligned square-wave segments into clk_period_monitor. Each table
// row is one segment (rising edge followed by len cycles) with the flags
// expected a few cycles after that row's rising edge. Expected periods are
// queued when a measuring rising edge is driven and popped whenever the DUT
// strobes period_valid. Timeout, enable drop and reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_clk_period_monitor;

    localparam int EXP  = 20;
    localparam int TOL  = 2;
    localparam int LOCK = 3;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic          en;
    logic          clr_err;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          err_fast;
    logic          err_slow;
    logic          err_timeout;

    always #5 clk = ~clk;

    clk_period_monitor #(
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK),
        .CW         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .en           (en),
        .clr_err      (clr_err),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .err_fast     (err_fast),
        .err_slow     (err_slow),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        int len;     // segment length in clk cycles
        int clr_at;  // loop index at which clr_err is pulsed, -1 for none
        bit locked;  // expected flags 4 cycles after this row's rising edge
        bit fast;
        bit slow;
        bit tmo;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_meas   = 1'b0;
    int   m_prev_len = 0;
    int   mon_exp;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] out_bits();
        return {rise_pulse, fall_pulse, period_valid, locked,
                err_fast, err_slow, err_timeout};
    endfunction

    // Scoreboard consumer: every period_valid must match a queued period.
    always @(negedge clk) begin
        if (period_valid) begin
            check("period_valid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("period_out", longint'(period_out), mon_exp);
            end
        end
    end

    task automatic run_row(input int idx);
        vec_t v;
        v = vecs[idx];
        if (en) begin
            if (m_meas) exp_q.push_back(m_prev_len);
            m_meas = 1'b1;
        end
        m_prev_len = v.len;
        sig_in = 1'b1;
        for (int i = 0; i < v.len; i++) begin
            if (i == v.len / 2) sig_in = 1'b0;
            step();
            clr_err = (i == v.clr_at);
            if (i == 3) begin
                check($sformatf("row%0d_locked", idx), locked, v.locked);
                check($sformatf("row%0d_err_fast", idx), err_fast, v.fast);
                check($sformatf("row%0d_err_slow", idx), err_slow, v.slow);
                check($sformatf("row%0d_err_timeout", idx), err_timeout, v.tmo);
            end
        end
        clr_err = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) run_row(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase A: lock, boundary sweep (rows 0-11)
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 1, 0, 0, 0});
        vecs.push_back('{18, -1, 1, 0, 0, 0});
        vecs.push_back('{22, -1, 1, 0, 0, 0});
        vecs.push_back('{17, -1, 1, 0, 0, 0});
        vecs.push_back('{23, -1, 0, 1, 0, 0});
        vecs.push_back('{20, -1, 0, 1, 1, 0});
        vecs.push_back('{20, -1, 0, 1, 1, 0});
        vecs.push_back('{20, -1, 0, 1, 1, 0});
        vecs.push_back('{20, -1, 1, 1, 1, 0});
        // Phase B: relock after timeout, clr_err corner cases (rows 12-21)
        vecs.push_back('{20, -1, 0, 1, 1, 1});
        vecs.push_back('{20, -1, 0, 1, 1, 1});
        vecs.push_back('{20, -1, 0, 1, 1, 1});
        vecs.push_back('{20, -1, 1, 1, 1, 1});
        vecs.push_back('{16, -1, 1, 1, 1, 1});
        vecs.push_back('{20,  1, 0, 1, 0, 0});
        vecs.push_back('{20, -1, 0, 1, 0, 0});
        vecs.push_back('{20, -1, 0, 1, 0, 0});
        vecs.push_back('{20,  8, 1, 1, 0, 0});
        vecs.push_back('{20, -1, 1, 0, 0, 0});
        // Phase C: after en re-enable (rows 22-25)
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 1, 0, 0, 0});
        // Phase D: after reset, edge at the timeout limit (rows 26-29)
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 0, 0});
        vecs.push_back('{40, -1, 0, 0, 0, 0});
        vecs.push_back('{20, -1, 0, 0, 1, 0});

        // Reset held with sig_in toggling and en high: outputs stay zero.
        rst = 1'b1; en = 1'b1; clr_err = 1'b0; sig_in = 1'b0;
        step();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) sig_in = ~sig_in;
            step();
            check($sformatf("reset_outputs_%0d", i), longint'(out_bits()), 0);
            check($sformatf("reset_period_out_%0d", i), longint'(period_out), 0);
        end

        // Released with en low: strobes still appear with fixed latency.
        sig_in = 1'b0; en = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        sig_in = 1'b1;
        step(); check("rise_lat_e0", rise_pulse, 0);
        step(); check("rise_lat_e1", rise_pulse, 1);
        check("fall_during_rise", fall_pulse, 0);
        step(); check("rise_lat_e2", rise_pulse, 0);
        sig_in = 1'b0;
        step(); check("fall_lat_e0", fall_pulse, 0);
        step(); check("fall_lat_e1", fall_pulse, 1);
        step(); check("fall_lat_e2", fall_pulse, 0);
        check("idle_locked", locked, 0);

        // Enable and run phase A.
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        run_rows(0, 11);

        // Hold sig_in low after lock: timeout fires when cnt reaches 2*EXP.
        for (int i = 0; i < 22; i++) step();
        check("pre_timeout_flag", err_timeout, 0);
        check("pre_timeout_locked", locked, 1);
        step();
        check("timeout_flag", err_timeout, 1);
        check("timeout_locked", locked, 0);
        m_meas = 1'b0;
        for (int i = 0; i < 5; i++) step();
        run_rows(12, 21);

        // Drop en mid-period: lock lost next cycle, no measurement taken.
        en = 1'b0;
        step();
        check("en_drop_locked", locked, 0);
        m_meas = 1'b0;
        for (int i = 0; i < 4; i++) step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        run_rows(22, 25);

        // Reset mid-period with en still high.
        rst = 1'b1;
        step();
        check("rst_mid_outputs", longint'(out_bits()), 0);
        step();
        rst = 1'b0;
        m_meas = 1'b0;
        for (int i = 0; i < 3; i++) step();
        run_rows(26, 29);

        for (int i = 0; i < 6; i++) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
# clk_period_monitor

Receive-side checker for the slow divided clock. Takes the divided square wave (`sclk`) back into the fast `clk` domain, synchronizes it, and measures every rising-edge-to-rising-edge period in `clk` cycles. It flags periods that are too short, too long or missing, and asserts `locked` after a run of in-tolerance periods. It sits beside the clock divider in the trust/monitor logic, so a tampered divide ratio or stalled slow clock is caught in hardware.

## Interface
Parameters:
- `EXP_PERIOD`, default 2000002: expected period in `clk` cycles (two half-periods of the divider at count 1000000).
- `TOL`, default 16: allowed absolute deviation from `EXP_PERIOD`, inclusive.
- `LOCK_CNT`, default 4: consecutive good periods required for `locked`.
- `CW`, default 32: counter and `period_out` width. Must satisfy 2*`EXP_PERIOD` < 2^`CW`.

Ports (single clock; reset is synchronous and active-high):
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `sig_in` in 1: monitored slow clock, asynchronous to `clk`.
- `en` in 1: measurement enable.
- `clr_err` in 1: clears sticky error flags.
- `rise_pulse` out 1: one-cycle strobe per synchronized rising edge.
- `fall_pulse` out 1: one-cycle strobe per synchronized falling edge.
- `period_out` out `CW`: last measured period.
- `period_valid` out 1: one-cycle strobe when `period_out` updates.
- `locked` out 1: `LOCK_CNT` consecutive good periods seen.
- `err_fast` out 1: sticky; a period below `EXP_PERIOD`−`TOL` was measured.
- `err_slow` out 1: sticky; a period above `EXP_PERIOD`+`TOL` was measured.
- `err_timeout` out 1: sticky; no rising edge for 2*`EXP_PERIOD` cycles.

## Operation
- **Synchronizer:** `sig_in` passes through flops s1 and s2, then a history flop s3.
  - `rise_pulse` = s2 & ~s3.
  - `fall_pulse` = ~s2 & s3.
  - The synchronizer runs regardless of `en`.
- **States:**
  - IDLE: `en` = 0.
  - ARM: waiting for the first rising edge.
  - MEASURE: counting.
- **Transitions:**
  - IDLE → ARM when `en` = 1.
  - ARM → MEASURE on `rise_pulse`, with cnt ← 1.
  - Any state → IDLE when `en` = 0. This clears cnt, the run counter and `locked`. `period_out` and the error flags hold.
- **MEASURE, no `rise_pulse`:** cnt ← cnt+1.
- **MEASURE, on `rise_pulse`:**
  - `period_out` ← cnt and `period_valid` ← 1.
  - Classify cnt, then cnt ← 1.
  - The reported period therefore equals the number of `clk` cycles between consecutive `rise_pulse` assertions.
- **Classification:**
  - Good when `EXP_PERIOD`−`TOL` ≤ cnt ≤ `EXP_PERIOD`+`TOL` (both bounds inclusive). The run counter increments and saturates at `LOCK_CNT`. `locked` ← 1 when the run counter reaches `LOCK_CNT`.
  - Below range: `err_fast` ← 1, run ← 0, `locked` ← 0.
  - Above range: `err_slow` ← 1, run ← 0, `locked` ← 0.
- **Timeout:** in MEASURE, when cnt = 2*`EXP_PERIOD` without `rise_pulse`:
  - `err_timeout` ← 1, `locked` ← 0, run ← 0.
  - Go to ARM. No `period_valid` is issued.
  - cnt never wraps.
- **Error flags:** sticky until `rst`, or until `clr_err` in a cycle with no new error event. If `clr_err` coincides with a new error event, set wins and only that flag stays set; the others clear.
- **Arithmetic:** unsigned, `CW` bits. Range bounds are computed from parameters at elaboration.

## Timing
- **Reset values:** every output is 0. s1, s2, s3, cnt and run are 0, and the state is IDLE.
- **Edge-detect latency:** a `sig_in` transition sampled at edge e0 drives `rise_pulse`/`fall_pulse` high from e1 to e2, for exactly one cycle.
- **Measurement latency:** `period_out`, `period_valid`, `locked` and the error flags update at e2, one cycle after `rise_pulse`.
- **`period_valid`:** high exactly one cycle per measured period.
- **Simultaneous events:**
  - `rise_pulse` in the same cycle cnt hits the timeout value: the edge wins. The period is measured and classified as slow.
  - `en` falling in the same cycle as `rise_pulse`: IDLE wins and no measurement is taken.
- **Reset mid-measurement:** `rst` takes priority over all inputs. It clears state within one cycle, and the first rising edge after release only arms.

## Test plan
Bench parameters: `EXP_PERIOD`=20, `TOL`=2, `LOCK_CNT`=3, `CW`=32.
- Assert `rst` with `sig_in` toggling → all outputs 0 for the whole reset; after release with `en`=0, `rise_pulse`/`fall_pulse` still appear but `period_valid` stays 0.
- `en`=1 and a 10-high/10-low square wave → no valid on the 1st rise; `period_valid` with `period_out`=20 after each later rise; `locked`=1 after the 3rd valid period; no error flags.
- Boundary sweep of periods 18, 22, 17, 23 → 18 and 22 good; 17 sets `err_fast` and drops `locked`; 23 sets `err_slow`.
- Hold `sig_in` low after lock → `err_timeout`=1 and `locked`=0 when cnt reaches 40, then state ARM; resuming the 20-cycle wave relocks after 1 arming rise plus 3 good periods.
- Pulse `clr_err` in the same cycle a 16-cycle period completes → `err_fast` remains 1 and `err_timeout` clears; a later isolated `clr_err` clears `err_fast`.
- Drop `en` mid-period, or assert `rst` mid-period → `locked` 0 the next cycle and no `period_valid`; after re-enable, the first measured period is a full 20, not a partial count.
